// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU control words and the main-decoder-to-ALU-decoder aluop.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXECUTE,
      ALUWB,
      BRANCH,
      ADDIEXEC,
      ADDIWB,
      JUMP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: fixed add/sub from the main FSM, or funct-driven for R-type.
module mips_aludec
   import mips_mc_pkg::*;
(
   input  logic [5:0] funct,
   input  logic [1:0] aluop,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               F_ADD:   alucontrol = ALU_ADD;
               F_SUB:   alucontrol = ALU_SUB;
               F_AND:   alucontrol = ALU_AND;
               F_OR:    alucontrol = ALU_OR;
               F_SLT:   alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM (Moore outputs) with ALU decoder.
// Define MIPS_MC_BNE_EN to support bne (branch on NOT zero); otherwise bne is illegal.
module mips_mc_control
   import mips_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal
);

   state_t     state, next_state, ostate;
   logic       pcwrite, branch, brcond;
   logic [1:0] aluop;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   // Under reset the outputs decode as FETCH so the mux selects hold their
   // FETCH values; the strobes are then forced low below.
   always_comb begin
      ostate     = reset ? FETCH : state;
      next_state = FETCH;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      illegal    = 1'b0;
      alusrca    = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = ALUOP_ADD;
      case (ostate)
         FETCH: begin
            alusrcb    = 2'b01;
            irwrite    = 1'b1;
            pcwrite    = 1'b1;
            next_state = DECODE;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE:     next_state = EXECUTE;
               OP_BEQ:       next_state = BRANCH;
`ifdef MIPS_MC_BNE_EN
               OP_BNE:       next_state = BRANCH;
`endif
               OP_ADDI:      next_state = ADDIEXEC;
               OP_J:         next_state = JUMP;
               default: begin
                  next_state = FETCH;
                  illegal    = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            next_state = (op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            iord       = 1'b1;
            next_state = MEMWB;
         end
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         EXECUTE: begin
            alusrca    = 1'b1;
            aluop      = ALUOP_FUNCT;
            next_state = ALUWB;
         end
         ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BRANCH: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEXEC: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            next_state = ADDIWB;
         end
         ADDIWB: begin
            regwrite = 1'b1;
         end
         JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: next_state = FETCH;
      endcase
      if (reset) begin
         pcwrite  = 1'b0;
         branch   = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
         illegal  = 1'b0;
      end
   end

`ifdef MIPS_MC_BNE_EN
   assign brcond = (op == OP_BNE) ? ~zero : zero;
`else
   assign brcond = zero;
`endif

   assign pcen = pcwrite | (branch & brcond);

   mips_aludec u_aludec (
      .funct      (funct),
      .aluop      (aluop),
      .alucontrol (alucontrol)
   );

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: per-cycle expected output vectors
// with care masks are queued by the stimulus and popped by a negedge monitor.
module tb_mips_mc_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'b000000;
   logic [5:0] funct = 6'b000000;
   logic       zero = 1'b0;
   logic       pcen, memwrite, irwrite, regwrite;
   logic       alusrca, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       illegal;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [15:0] val;
      logic [15:0] mask;
   } exp_t;

   exp_t q[$];

   // Vector layout: {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,
   // regdst,alusrcb[1:0],pcsrc[1:0],alucontrol[2:0],illegal}
   localparam logic [15:0] V_RST  = 16'h0044, M_RST  = 16'hFCFF;
   localparam logic [15:0] V_F    = 16'hA044, M_F    = 16'hFCFF;
   localparam logic [15:0] V_D    = 16'h00C4, M_D    = 16'hF8CF;
   localparam logic [15:0] V_DILL = 16'h00C5;
   localparam logic [15:0] V_MA   = 16'h0884, M_MA   = 16'hF8CF;
   localparam logic [15:0] V_MRD  = 16'h0400, M_MRD  = 16'hF401;
   localparam logic [15:0] V_MWB  = 16'h1200, M_WB   = 16'hF301;
   localparam logic [15:0] V_MWR  = 16'h4400;
   localparam logic [15:0] V_AWB  = 16'h1100;
   localparam logic [15:0] V_IWB  = 16'h1000;
   localparam logic [15:0] V_BR1  = 16'h881C, V_BR0 = 16'h081C, M_BR = 16'hF8FF;
   localparam logic [15:0] V_J    = 16'h8020, M_J    = 16'hF031;

   mips_mc_control dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic step(input string tag, input logic [15:0] val, input logic [15:0] mask);
      exp_t e;
      e.tag  = tag;
      e.val  = val;
      e.mask = mask;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] act;
      act = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
             alusrcb, pcsrc, alucontrol, illegal};
      total++;
      if ((int'(memwrite) + int'(regwrite) + int'(irwrite)) > 1) begin
         bad++;
         $display("FAIL onehot_strobes: got mw=%b rw=%b ir=%b, need at most one high",
                  memwrite, regwrite, irwrite);
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         total++;
         if (((act ^ e.val) & e.mask) !== 16'h0000) begin
            bad++;
            $display("FAIL %s: got %h want %h (mask %h) at %0t", e.tag, act, e.val, e.mask, $time);
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      step("rst0", V_RST, M_RST);
      step("rst1", V_RST, M_RST);
      step("rst2", V_RST, M_RST);
      reset = 1'b0;

      op = 6'b100011;
      step("lw_f", V_F, M_F);
      step("lw_d", V_D, M_D);
      step("lw_ma", V_MA, M_MA);
      step("lw_rd", V_MRD, M_MRD);
      step("lw_wb", V_MWB, M_WB);

      op = 6'b101011;
      step("sw_f", V_F, M_F);
      step("sw_d", V_D, M_D);
      step("sw_ma", V_MA, M_MA);
      step("sw_wr", V_MWR, M_MRD);

      op = 6'b000000;
      funct = 6'b101010;
      step("slt_f", V_F, M_F);
      step("slt_d", V_D, M_D);
      step("slt_ex", 16'h080E, M_MA);
      step("slt_wb", V_AWB, M_WB);
      funct = 6'b100010;
      step("sub_f", V_F, M_F);
      step("sub_d", V_D, M_D);
      step("sub_ex", 16'h080C, M_MA);
      step("sub_wb", V_AWB, M_WB);
      funct = 6'b100101;
      step("or_f", V_F, M_F);
      step("or_d", V_D, M_D);
      step("or_ex", 16'h0802, M_MA);
      step("or_wb", V_AWB, M_WB);
      funct = 6'b100100;
      step("and_f", V_F, M_F);
      step("and_d", V_D, M_D);
      step("and_ex", 16'h0800, M_MA);
      step("and_wb", V_AWB, M_WB);
      funct = 6'b111111;
      step("dflt_f", V_F, M_F);
      step("dflt_d", V_D, M_D);
      step("dflt_ex", 16'h0804, M_MA);
      step("dflt_wb", V_AWB, M_WB);

      op = 6'b000100;
      zero = 1'b1;
      step("beq1_f", V_F, M_F);
      step("beq1_d", V_D, M_D);
      step("beq1_br", V_BR1, M_BR);
      zero = 1'b0;
      step("beq0_f", V_F, M_F);
      step("beq0_d", V_D, M_D);
      step("beq0_br", V_BR0, M_BR);

      op = 6'b001000;
      step("addi_f", V_F, M_F);
      step("addi_d", V_D, M_D);
      step("addi_ex", V_MA, M_MA);
      step("addi_wb", V_IWB, M_WB);

      op = 6'b000010;
      step("j_f", V_F, M_F);
      step("j_d", V_D, M_D);
      step("j_jmp", V_J, M_J);

      op = 6'b000101;
`ifdef MIPS_MC_BNE_EN
      zero = 1'b0;
      step("bne0_f", V_F, M_F);
      step("bne0_d", V_D, M_D);
      step("bne0_br", V_BR1, M_BR);
      zero = 1'b1;
      step("bne1_f", V_F, M_F);
      step("bne1_d", V_D, M_D);
      step("bne1_br", V_BR0, M_BR);
`else
      zero = 1'b0;
      step("bne_f", V_F, M_F);
      step("bne_ill", V_DILL, M_D);
`endif

      op = 6'b111111;
      step("bad_f", V_F, M_F);
      step("bad_ill", V_DILL, M_D);
      step("bad_next", V_F, M_F);

      op = 6'b101011;
      step("swr_d", V_D, M_D);
      step("swr_ma", V_MA, M_MA);
      reset = 1'b1;
      step("swr_rst", V_RST, M_RST);
      reset = 1'b0;
      step("swr_f", V_F, M_F);
      step("swr_d2", V_D, M_D);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL be fixed constants.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode field from the instruction register.
REQ-005 funct  input  6  R-type funct field.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pcen  output  1  PC register enable: pcwrite OR (branch AND branch-condition).
REQ-008 memwrite, irwrite, regwrite  output  1 each  memory write, IR load, register-file write strobes.
REQ-009 alusrca, iord, memtoreg, regdst  output  1 each  datapath mux selects.
REQ-010 alusrcb, pcsrc  output  2 each  ALU-B select (00 reg, 01 const 4, 10 signimm, 11 signimm<<2); PC select (00 ALU, 01 ALUOut, 10 jump target).
REQ-011 alucontrol  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 illegal  output  1  one-cycle pulse in DECODE when op is unsupported.

Function
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP; outputs SHALL be Moore functions of state (alucontrol also of funct in EXECUTE).
REQ-014 FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00, irwrite=1, pcwrite=1; next DECODE.
REQ-015 DECODE: alusrca=0, alusrcb=11, add; next by op: lw/sw (100011/101011) MEMADR, R-type (000000) EXECUTE, beq (000100) BRANCH, addi (001000) ADDIEXEC, j (000010) JUMP, else FETCH with illegal=1.
REQ-016 MEMADR: alusrca=1, alusrcb=10, add; next MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD: iord=1 -> MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH; MEMWR: iord=1, memwrite=1 -> FETCH.
REQ-018 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other 010) -> ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
REQ-019 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1; condition = zero; next FETCH.
REQ-020 ADDIEXEC: alusrca=1, alusrcb=10, add -> ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
REQ-021 JUMP: pcsrc=10, pcwrite=1; next FETCH.
REQ-022 Latencies SHALL be lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; every strobe not listed for a state SHALL be 0.
REQ-023 At most one of memwrite, regwrite, irwrite SHALL be high in any cycle.

Reset
REQ-024 reset high at a rising edge SHALL force state FETCH irrespective of current state, including mid-instruction (e.g. during MEMWR).
REQ-025 While reset is high all strobes (pcen, memwrite, irwrite, regwrite, illegal) SHALL be 0; mux selects SHALL hold FETCH values.
REQ-026 First FETCH outputs SHALL appear the first cycle after reset deasserts.

Configuration
REQ-027 With MIPS_MC_BNE_EN defined, op 000101 (bne) SHALL go DECODE -> BRANCH with condition = NOT zero; otherwise bne SHALL be illegal (illegal=1, back to FETCH).

Structure
REQ-028 A shared package mips_mc_pkg SHALL hold the state enum, opcode, funct and alucontrol constants.
REQ-029 ALU decoding SHALL be one combinational sub-module mips_aludec (inputs funct and 2-bit aluop, output alucontrol).

Verification
REQ-030 reset held 3 cycles then released -> cycle 1 irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
REQ-031 op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-032 op=000000, funct=101010 -> EXECUTE alucontrol=111; ALUWB regdst=1, regwrite=1; 4 cycles total.
REQ-033 op=000100 with zero=1 -> pcen=1, pcsrc=01 in cycle 3; with zero=0 -> pcen=0 in cycle 3.
REQ-034 op=101011 then reset asserted during MEMWR -> memwrite=0 that cycle-after, state FETCH next.
REQ-035 op=000101: with MIPS_MC_BNE_EN and zero=0 -> pcen=1 in cycle 3; without it -> illegal=1 in DECODE, FETCH next.
